memoria_blocos: RTL and testbench
=================================

# memoria_blocos

Parametrised block-transfer main memory behind the instruction and data caches. Serves one aligned multi-word block per transaction, read (cache miss refill) or write (dirty-line write-back), after a programmable latency, with a single-cycle completion pulse. Generalises block width, memory depth and latency, and adds block writes and out-of-range detection.

## Interface
- DATA_W, 32, bits per word
- WORDS, 4, words per block; power of two, ≥1
- DEPTH_WORDS, 1024, memory depth in words; power of two, multiple of WORDS
- LATENCIA, 1, cycles from acceptance to completion; ≥1, ≤255
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- req_leitura  input  1  block read request; held until memoria_pronta
- req_escrita  input  1  block write request; held until memoria_pronta
- endereco  input  32  byte address; any byte inside the target block
- dado_escrita  input  DATA_W*WORDS  write block; word i at [DATA_W*i +: DATA_W]
- bloco_lido  output  DATA_W*WORDS  read block, same packing; word 0 = lowest address
- memoria_pronta  output  1  one-cycle completion pulse
- erro_endereco  output  1  valid with memoria_pronta; access was out of range
- ocupado  output  1  high in WAIT and RESP

## Operation
- Block base = endereco with low log2(WORDS*DATA_W/8) bits cleared; word index = base/(DATA_W/8) + i.
- Out of range: base ≥ DEPTH_WORDS*DATA_W/8. No memory access, no write, bloco_lido unchanged, erro_endereco=1 with the pronta pulse.
- FSM states IDLE, WAIT, RESP.
- IDLE: if req_escrita or req_leitura, latch base, operation and dado_escrita; contador <= LATENCIA; go WAIT. Both high: write wins, read dropped (requester re-issues).
- WAIT: contador decrements each edge. On the edge with contador==1: perform access (read loads all WORDS words into bloco_lido; write stores all WORDS words), memoria_pronta <= 1, erro_endereco per range check, go RESP.
- RESP: memoria_pronta <= 0, erro_endereco <= 0, go IDLE. Requests ignored in RESP and WAIT (not queued).
- Inputs other than at the accept edge are don't-care; latched values are used.
- bloco_lido holds the last successful read; writes never change it.
- Memory array is not reset; contents are preserved across reset.

## Timing
- Reset (async): state IDLE, contador 0, bloco_lido 0, memoria_pronta 0, erro_endereco 0, ocupado 0. Reset during WAIT aborts; pending write discarded, array untouched.
- Accept at edge t0 → memoria_pronta high in cycle after edge t0+LATENCIA, exactly one cycle.
- ocupado rises after the accept edge, falls after the RESP edge.
- Earliest next accept: edge t0+LATENCIA+2. Requester must drop req on the edge ending the pronta cycle; still-high req at the next IDLE edge starts a new transaction.
- Write followed by read of the same block returns new data.

## Test plan
- WORDS=4, LATENCIA=1, read endereco 0x0000_0014, array words 4..7 = 0xA,0xB,0xC,0xD → pronta one cycle after accept edge+1, bloco_lido = {0xD,0xC,0xB,0xA}, erro 0.
- LATENCIA=5, write block 0x20 with {4,3,2,1} then read 0x2C → each pronta 5 cycles after accept, read returns {4,3,2,1}, bloco_lido unchanged after write.
- req_leitura and req_escrita high together → write performed, one pronta only; req held high through RESP → second transaction accepted exactly LATENCIA+2 edges after first.
- DEPTH_WORDS=1024, read 0x0000_1000 → pronta with erro_endereco=1, bloco_lido keeps previous value; write 0x1000 → array unchanged.
- Reset asserted mid-WAIT of a write → outputs zero immediately, no pronta, later read of that block returns old data.
- WORDS=8, DATA_W=16, LATENCIA=3, read 0x13 → base 0x10, words 8..15 returned, word 8 in bits [15:0].

Source files
------------

// File: rtl/memoria_blocos.sv
// Block-transfer main memory: serves one aligned WORDS-word block per request
// (refill read or write-back) after LATENCIA cycles, with a one-cycle done pulse.
module memoria_blocos #(
  parameter int DATA_W      = 32,
  parameter int WORDS       = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCIA    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_leitura,
  input  logic                    req_escrita,
  input  logic [31:0]             endereco,
  input  logic [DATA_W*WORDS-1:0] dado_escrita,
  output logic [DATA_W*WORDS-1:0] bloco_lido,
  output logic                    memoria_pronta,
  output logic                    erro_endereco,
  output logic                    ocupado
);
  localparam int BLOCK_W     = DATA_W * WORDS;
  localparam int BLOCK_BYTES = (DATA_W / 8) * WORDS;
  localparam int OFF_W       = $clog2(BLOCK_BYTES);
  localparam int NUM_BLOCKS  = DEPTH_WORDS / WORDS;
  localparam int IDX_W       = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int BLK_W       = 32 - OFF_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} estado_t;

  estado_t              estado, prox_estado;
  logic [7:0]           contador;
  logic                 aceita, conclui;
  logic                 op_escrita;
  logic [BLK_W-1:0]     bloco_num;
  logic [BLOCK_W-1:0]   dado_lat;
  logic                 em_faixa;
  logic [IDX_W-1:0]     idx;
  logic [31:0]          unused_offset;

  // Stored one block per row so a whole block moves in a single edge.
  logic [BLOCK_W-1:0]   mem [NUM_BLOCKS];

  // The byte offset inside a block never selects anything.
  assign unused_offset = endereco & 32'(BLOCK_BYTES - 1);

  assign em_faixa = (bloco_num < BLK_W'(NUM_BLOCKS));
  assign idx      = bloco_num[IDX_W-1:0];
  assign ocupado  = (estado != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= IDLE;
    else       estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    aceita      = 1'b0;
    conclui     = 1'b0;
    case (estado)
      IDLE: begin
        if (req_escrita || req_leitura) begin
          aceita      = 1'b1;
          prox_estado = WAIT;
        end
      end
      WAIT: begin
        if (contador == 8'd1) begin
          conclui     = 1'b1;
          prox_estado = RESP;
        end
      end
      RESP:    prox_estado = IDLE;
      default: prox_estado = IDLE;
    endcase
  end

  // Control and visible outputs: cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador       <= 8'd0;
      memoria_pronta <= 1'b0;
      erro_endereco  <= 1'b0;
      bloco_lido     <= '0;
    end else begin
      if (aceita) begin
        contador <= 8'(LATENCIA);
      end else if (estado == WAIT) begin
        contador <= contador - 8'd1;
      end
      if (conclui) begin
        memoria_pronta <= 1'b1;
        erro_endereco  <= ~em_faixa;
        if (em_faixa && !op_escrita) begin
          bloco_lido <= mem[idx];
        end
      end else if (estado == RESP) begin
        memoria_pronta <= 1'b0;
        erro_endereco  <= 1'b0;
      end
    end
  end

  // Request latch and storage array: never reset, so contents survive reset.
  always_ff @(posedge clock) begin
    if (aceita) begin
      op_escrita <= req_escrita;
      bloco_num  <= endereco[31:OFF_W];
      dado_lat   <= dado_escrita;
    end
    if (conclui && em_faixa && op_escrita) begin
      mem[idx] <= dado_lat;
    end
  end

endmodule

// File: tb/tb_memoria_blocos.sv
// Bench for memoria_blocos: three configurations checked every cycle against a
// transaction-level model, plus directed transactions with literal expectations.
module tb_memoria_blocos;
  localparam int N      = 3;
  localparam int BW     = 128;
  localparam int DEPTH  = 1024;
  localparam int BLK_BY = 16;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 5;
      default: return 3;
    endcase
  endfunction

  function automatic int dw_of(input int k);
    return (k == 2) ? 16 : 32;
  endfunction

  function automatic int nw_of(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_l  [N];
  logic          req_e  [N];
  logic [31:0]   ender  [N];
  logic [BW-1:0] dado   [N];
  logic [BW-1:0] bloco  [N];
  logic          pronta [N];
  logic          erro   [N];
  logic          ocup   [N];

  always #5 clock = ~clock;

  memoria_blocos #(.DATA_W(32), .WORDS(4), .DEPTH_WORDS(DEPTH), .LATENCIA(1)) dut_a (
    .clock(clock), .reset(reset), .req_leitura(req_l[0]), .req_escrita(req_e[0]),
    .endereco(ender[0]), .dado_escrita(dado[0]), .bloco_lido(bloco[0]),
    .memoria_pronta(pronta[0]), .erro_endereco(erro[0]), .ocupado(ocup[0]));

  memoria_blocos #(.DATA_W(32), .WORDS(4), .DEPTH_WORDS(DEPTH), .LATENCIA(5)) dut_b (
    .clock(clock), .reset(reset), .req_leitura(req_l[1]), .req_escrita(req_e[1]),
    .endereco(ender[1]), .dado_escrita(dado[1]), .bloco_lido(bloco[1]),
    .memoria_pronta(pronta[1]), .erro_endereco(erro[1]), .ocupado(ocup[1]));

  memoria_blocos #(.DATA_W(16), .WORDS(8), .DEPTH_WORDS(DEPTH), .LATENCIA(3)) dut_c (
    .clock(clock), .reset(reset), .req_leitura(req_l[2]), .req_escrita(req_e[2]),
    .endereco(ender[2]), .dado_escrita(dado[2]), .bloco_lido(bloco[2]),
    .memoria_pronta(pronta[2]), .erro_endereco(erro[2]), .ocupado(ocup[2]));

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a request seen while idle completes LAT edges later,
  // the unit is released one edge after that, memory kept as plain word arrays.
  int unsigned   cyc = 0;
  logic          m_busy  [N];
  int unsigned   m_done  [N];
  logic          m_wr    [N];
  logic [31:0]   m_base  [N];
  logic [BW-1:0] m_dado  [N];
  logic          m_pronta[N];
  logic          m_erro  [N];
  logic [BW-1:0] m_bloco [N];
  logic [31:0]   m_mem   [N][DEPTH];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        m_busy[k] = 1'b0; m_pronta[k] = 1'b0; m_erro[k] = 1'b0; m_bloco[k] = '0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < N; k++) begin
        if (!m_busy[k]) begin
          if (req_e[k] || req_l[k]) begin
            m_busy[k] = 1'b1;
            m_done[k] = cyc + lat_of(k);
            m_wr[k]   = req_e[k];
            m_base[k] = ender[k] & ~32'(BLK_BY - 1);
            m_dado[k] = dado[k];
          end
        end else if (cyc == m_done[k]) begin
          m_pronta[k] = 1'b1;
          if (m_base[k] >= 32'(DEPTH * dw_of(k) / 8)) begin
            m_erro[k] = 1'b1;
          end else begin
            int unsigned wi;
            logic [31:0] msk;
            logic [BW-1:0] acc;
            m_erro[k] = 1'b0;
            wi  = m_base[k] / (dw_of(k) / 8);
            msk = (dw_of(k) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            acc = '0;
            for (int i = 0; i < nw_of(k); i++) begin
              if (m_wr[k]) m_mem[k][wi + i] = 32'(m_dado[k] >> (dw_of(k) * i)) & msk;
              else         acc = acc | (BW'(m_mem[k][wi + i] & msk) << (dw_of(k) * i));
            end
            if (!m_wr[k]) m_bloco[k] = acc;
          end
        end else if (cyc == m_done[k] + 1) begin
          m_busy[k] = 1'b0; m_pronta[k] = 1'b0; m_erro[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("pronta[%0d]", k), BW'(pronta[k]), BW'(m_pronta[k]));
        check($sformatf("erro[%0d]", k),   BW'(erro[k]),   BW'(m_erro[k]));
        check($sformatf("ocupado[%0d]", k), BW'(ocup[k]),  BW'(m_busy[k]));
        check($sformatf("bloco[%0d]", k),  bloco[k],       m_bloco[k]);
      end
    end
  end

  // One request held until the pronta cycle, then dropped.
  task automatic txn(input int k, input bit wr, input bit rd, input logic [31:0] a,
                     input logic [BW-1:0] d, output int lat, output logic er);
    @(negedge clock);
    req_e[k] = wr; req_l[k] = rd; ender[k] = a; dado[k] = d;
    lat = -1; er = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clock);
      if (pronta[k]) begin
        lat = n - 1; er = erro[k];
        break;
      end
    end
    req_e[k] = 1'b0; req_l[k] = 1'b0;
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL timeout[%0d] actual=no_pronta required=pronta", k);
    end
  endtask

  localparam logic [BW-1:0] BLK_DCBA = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [BW-1:0] BLK_8765 = 128'h00000008_00000007_00000006_00000005;
  localparam logic [BW-1:0] BLK_4321 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [BW-1:0] BLK_DUAL = 128'h11112222_33334444_55556666_77778888;
  localparam logic [BW-1:0] BLK_P    = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
  localparam logic [BW-1:0] BLK_Q    = 128'hBAD00003_BAD00002_BAD00001_BAD00000;
  localparam logic [BW-1:0] BLK_OLD  = 128'h01010101_02020202_03030303_04040404;
  localparam logic [BW-1:0] BLK_NEW  = 128'hF0F0F0F0_E0E0E0E0_D0D0D0D0_C0C0C0C0;
  localparam logic [BW-1:0] BLK_W16  = 128'hA00F_A00E_A00D_A00C_A00B_A00A_A009_A008;

  initial begin
    int lat;
    logic er;
    int p1, p2;
    for (int k = 0; k < N; k++) begin
      req_l[k] = 1'b0; req_e[k] = 1'b0; ender[k] = '0; dado[k] = '0;
    end

    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_bloco[%0d]", k), bloco[k], '0);
      check($sformatf("rst_pronta[%0d]", k), BW'(pronta[k]), '0);
      check($sformatf("rst_erro[%0d]", k), BW'(erro[k]), '0);
      check($sformatf("rst_ocupado[%0d]", k), BW'(ocup[k]), '0);
    end
    cmp_en = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // LATENCIA=1: fill words 4..7, then read via an unaligned byte address.
    txn(0, 1'b1, 1'b0, 32'h0000_0010, BLK_DCBA, lat, er);
    check("a_wr_lat", BW'(lat), BW'(1));
    check("a_wr_keeps_bloco", bloco[0], '0);
    txn(0, 1'b0, 1'b1, 32'h0000_0014, '0, lat, er);
    check("a_rd_lat", BW'(lat), BW'(1));
    check("a_rd_erro", BW'(er), '0);
    check("a_rd_bloco", bloco[0], BLK_DCBA);

    // LATENCIA=5: write then read back; a write leaves bloco_lido alone.
    txn(1, 1'b1, 1'b0, 32'h0000_0030, BLK_8765, lat, er);
    txn(1, 1'b0, 1'b1, 32'h0000_0030, '0, lat, er);
    check("b_rd30_bloco", bloco[1], BLK_8765);
    txn(1, 1'b1, 1'b0, 32'h0000_0020, BLK_4321, lat, er);
    check("b_wr_lat", BW'(lat), BW'(5));
    check("b_wr_keeps_bloco", bloco[1], BLK_8765);
    txn(1, 1'b0, 1'b1, 32'h0000_002C, '0, lat, er);
    check("b_rd_lat", BW'(lat), BW'(5));
    check("b_rd_bloco", bloco[1], BLK_4321);

    // Both requests held high: writes win, back-to-back every LATENCIA+2 edges.
    @(negedge clock);
    req_e[0] = 1'b1; req_l[0] = 1'b1; ender[0] = 32'h0000_0050; dado[0] = BLK_DUAL;
    p1 = -1; p2 = -1;
    for (int n = 1; n <= 40 && p2 < 0; n++) begin
      @(negedge clock);
      if (pronta[0]) begin
        if (p1 < 0) p1 = n;
        else        p2 = n;
      end
    end
    req_e[0] = 1'b0; req_l[0] = 1'b0;
    check("dual_first", BW'(p1), BW'(2));
    check("dual_gap", BW'(p2 - p1), BW'(3));
    check("dual_no_read", bloco[0], BLK_DCBA);
    txn(0, 1'b0, 1'b1, 32'h0000_0058, '0, lat, er);
    check("dual_written", bloco[0], BLK_DUAL);

    // Out of range: flagged, no read, no write (no aliasing onto block 0).
    txn(0, 1'b1, 1'b0, 32'h0000_0000, BLK_P, lat, er);
    txn(0, 1'b0, 1'b1, 32'h0000_0004, '0, lat, er);
    check("oor_pre_bloco", bloco[0], BLK_P);
    txn(0, 1'b0, 1'b1, 32'h0000_1000, '0, lat, er);
    check("oor_rd_erro", BW'(er), BW'(1));
    check("oor_rd_lat", BW'(lat), BW'(1));
    check("oor_rd_keeps", bloco[0], BLK_P);
    txn(0, 1'b1, 1'b0, 32'h0000_1000, BLK_Q, lat, er);
    check("oor_wr_erro", BW'(er), BW'(1));
    txn(0, 1'b0, 1'b1, 32'h0000_0000, '0, lat, er);
    check("oor_wr_no_alias", bloco[0], BLK_P);
    check("inrange_erro", BW'(er), '0);

    // Reset mid-WAIT of a write: aborted, array keeps the old block.
    txn(1, 1'b1, 1'b0, 32'h0000_0040, BLK_OLD, lat, er);
    @(negedge clock);
    req_e[1] = 1'b1; ender[1] = 32'h0000_0040; dado[1] = BLK_NEW;
    repeat (3) @(negedge clock);
    check("abort_in_wait", BW'(ocup[1]), BW'(1));
    #1 reset = 1'b1;
    #1;
    check("abort_ocupado", BW'(ocup[1]), '0);
    check("abort_pronta", BW'(pronta[1]), '0);
    check("abort_bloco", bloco[1], '0);
    req_e[1] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    txn(1, 1'b0, 1'b1, 32'h0000_0048, '0, lat, er);
    check("abort_old_data", bloco[1], BLK_OLD);

    // WORDS=8, DATA_W=16, LATENCIA=3: read 0x13 returns words 8..15.
    txn(2, 1'b1, 1'b0, 32'h0000_0010, BLK_W16, lat, er);
    txn(2, 1'b0, 1'b1, 32'h0000_0013, '0, lat, er);
    check("c_rd_lat", BW'(lat), BW'(3));
    check("c_rd_bloco", bloco[2], BLK_W16);
    check("c_word8_low", BW'(bloco[2][15:0]), BW'(16'hA008));
    txn(2, 1'b0, 1'b1, 32'h0000_0800, '0, lat, er);
    check("c_oor_erro", BW'(er), BW'(1));
    check("c_oor_keeps", bloco[2], BLK_W16);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
